rf_write_port_ctrl: RTL and testbench

- Writer-side controller for the 32x32 register file's single write port; produces `we`/`writeRegister`/`writeData` each cycle.
- Merges two result sources:
  - the in-order pipeline writeback stage, which has priority;
  - a long-latency multiply/divide unit (MDU), whose results are buffered in a small FIFO until a port slot frees.
- Also provides a lookup port so decode/forwarding logic can see results that are queued but not yet written.

---
 rtl/rf_write_port_ctrl.sv | 111 +++++++++++
 tb/tb_rf_write_port_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rf_write_port_ctrl.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and MDU results
// wait in a small FIFO with a squash rule, a starvation guard and a lookup path.
module rf_write_port_ctrl #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [ADDR_W-1:0]        pipe_rd,
  input  logic [DATA_W-1:0]        pipe_data,
  output logic                     pipe_stall,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [ADDR_W-1:0]        mdu_rd,
  input  logic [DATA_W-1:0]        mdu_data,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  input  logic [ADDR_W-1:0]        lk_addr,
  output logic                     lk_hit,
  output logic [DATA_W-1:0]        lk_data,
  output logic [$clog2(DEPTH):0]   pending_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MAX_WAIT + 1);

  logic [DEPTH-1:0][ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [DEPTH-1:0]             live_q;
  logic [PW-1:0]                wptr_q, rptr_q;
  logic [CW-1:0]                cnt_q;
  logic [AW-1:0]                age_q, age_d;
  logic                         rf_we_q;
  logic [ADDR_W-1:0]            rf_waddr_q;
  logic [DATA_W-1:0]            rf_wdata_q;

  logic empty, full, pipe_wr, push, pop, push_live;

  assign empty      = (cnt_q == '0);
  assign full       = (cnt_q == CW'(DEPTH));
  assign mdu_ready  = !full;
  assign pipe_stall = (int'(age_q) >= MAX_WAIT);
  assign pipe_wr    = pipe_we && !pipe_stall && (pipe_rd != '0);
  assign push       = mdu_valid && !full;
  assign pop        = !empty && !pipe_wr;
  // An MDU entry accepted alongside a same-rd pipeline write is older than it: born dead.
  assign push_live  = (mdu_rd != '0) && !(pipe_wr && (mdu_rd == pipe_rd));
  assign age_d      = (empty || pop) ? '0 : age_q + AW'(1);

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign pending_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      data_q     <= '0;
      live_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      age_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (pipe_wr && (rd_q[i] == pipe_rd)) live_q[i] <= 1'b0;
      if (push) begin
        rd_q[wptr_q]   <= mdu_rd;
        data_q[wptr_q] <= mdu_data;
        live_q[wptr_q] <= push_live;
        wptr_q         <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      age_q <= age_d;

      rf_we_q <= 1'b0;
      if (pipe_wr) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= pipe_rd;
        rf_wdata_q <= pipe_data;
      end else if (pop && live_q[rptr_q]) begin
        rf_we_q    <= 1'b1;
        rf_waddr_q <= rd_q[rptr_q];
        rf_wdata_q <= data_q[rptr_q];
      end
    end
  end

  // Walk oldest to youngest so the last match is the youngest live entry.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if ((CW'(k) < cnt_q) && live_q[idx] && (rd_q[idx] == lk_addr) && (lk_addr != '0)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[idx];
      end
    end
  end
endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// Directed bench for rf_write_port_ctrl with hand-computed expectations.
module tb_rf_write_port_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we, pipe_stall, mdu_valid, mdu_ready, rf_we, lk_hit;
  logic [4:0]  pipe_rd, mdu_rd, rf_waddr, lk_addr;
  logic [31:0] pipe_data, mdu_data, rf_wdata, lk_data;
  logic [2:0]  pending_cnt;
  int          n_chk = 0, n_pass = 0;

  rf_write_port_ctrl #(.DEPTH(4), .MAX_WAIT(8), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    pipe_we = we; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    mdu_valid = v; mdu_rd = rd; mdu_data = d;
  endtask

  initial begin
    rst = 1'b1;
    pipe(0, 0, 0); mdu(0, 0, 0); lk_addr = 0;
    #3;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_pending", pending_cnt, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_lk_hit", lk_hit, 0);
    chk("rst_lk_data", lk_data, 0);
    chk("rst_ready", mdu_ready, 1);
    tick(); rst = 1'b0; tick();

    // plain pipeline write, then rd=0 is dropped and address/data hold
    pipe(1, 5, 32'hDEADBEEF); tick();
    chk("p1_we", rf_we, 1);
    chk("p1_waddr", rf_waddr, 5);
    chk("p1_wdata", rf_wdata, 32'hDEADBEEF);
    pipe(1, 0, 32'h123); tick();
    chk("p1_r0_we", rf_we, 0);
    chk("p1_r0_hold", rf_waddr, 5);

    // fill FIFO while the pipeline owns the port
    for (int k = 0; k < 4; k++) begin
      pipe(1, 20, 32'h100 + k);
      mdu(1, 5'(k + 1), 32'h10 * (k + 1));
      chk($sformatf("fill_ready%0d", k), mdu_ready, 1);
      tick();
    end
    mdu(0, 0, 0);
    chk("full_ready", mdu_ready, 0);
    chk("full_cnt", pending_cnt, 4);
    chk("fill_pipe_wr", rf_waddr, 20);
    lk_addr = 3; #1;
    chk("lk3_hit", lk_hit, 1);
    chk("lk3_data", lk_data, 32'h30);
    lk_addr = 0; #1;
    chk("lk0_hit", lk_hit, 0);
    // age is 3 after the 4th push; five more blocked cycles reach 8
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("no_stall%0d", k), pipe_stall, 0);
      tick();
    end
    chk("stall_on", pipe_stall, 1);
    tick();
    chk("drain_we", rf_we, 1);
    chk("drain_waddr", rf_waddr, 1);
    chk("drain_wdata", rf_wdata, 32'h10);
    chk("drain_cnt", pending_cnt, 3);
    chk("stall_off", pipe_stall, 0);

    // one more entry behind a pipeline write, then drain in order
    mdu(1, 5, 32'h50); tick(); mdu(0, 0, 0);
    chk("refill_cnt", pending_cnt, 4);
    pipe(0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fifo_we%0d", k), rf_we, 1);
      chk($sformatf("fifo_waddr%0d", k), rf_waddr, 5'(k + 2));
      chk($sformatf("fifo_wdata%0d", k), rf_wdata, 32'h10 * (k + 2));
    end
    chk("drained_cnt", pending_cnt, 0);
    tick();
    chk("idle_we", rf_we, 0);

    // squash of an older queued entry
    mdu(1, 7, 32'hAA); tick(); mdu(0, 0, 0);
    lk_addr = 7;
    pipe(1, 7, 32'hBB); #1;
    chk("sq_lk_pre", lk_hit, 1);
    chk("sq_lk_pre_d", lk_data, 32'hAA);
    tick();
    chk("sq_waddr", rf_waddr, 7);
    chk("sq_wdata", rf_wdata, 32'hBB);
    chk("sq_lk_post", lk_hit, 0);
    chk("sq_cnt", pending_cnt, 1);
    pipe(0, 0, 0); tick();
    chk("sq_dead_we", rf_we, 0);
    chk("sq_dead_cnt", pending_cnt, 0);
    chk("sq_dead_hold", rf_wdata, 32'hBB);

    // same-cycle accept and pipeline write to r9
    mdu(1, 9, 32'h99); pipe(1, 9, 32'h999); lk_addr = 9; tick();
    mdu(0, 0, 0); pipe(0, 0, 0);
    chk("sc_wdata", rf_wdata, 32'h999);
    chk("sc_lk", lk_hit, 0);
    tick();
    chk("sc_dead_we", rf_we, 0);
    chk("sc_cnt", pending_cnt, 0);

    // two entries for r2: youngest wins, then an async reset mid-queue
    pipe(1, 30, 32'h3); mdu(1, 2, 32'h1); tick();
    mdu(1, 2, 32'h2); tick();
    mdu(1, 4, 32'h4); tick();
    mdu(0, 0, 0); lk_addr = 2; #1;
    chk("yng_hit", lk_hit, 1);
    chk("yng_data", lk_data, 32'h2);
    chk("yng_cnt", pending_cnt, 3);
    chk("pre_rst_we", rf_we, 1);
    #2 rst = 1'b1; #1;
    chk("arst_cnt", pending_cnt, 0);
    chk("arst_we", rf_we, 0);
    chk("arst_ready", mdu_ready, 1);
    chk("arst_lk", lk_hit, 0);
    pipe(0, 0, 0);
    tick(); rst = 1'b0; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
